// File: rtl/dma_xfer_datapath_pkg.sv
// ============================================================================
// DmaPackage -- shared types, register-select codes and byte-count helper
// for the dma_xfer_datapath block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package DmaPackage;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_ACTIVE = 2'd2
  } dma_state_e;

  localparam logic ADDR_SEL = 1'b0;
  localparam logic CNT_SEL  = 1'b1;

  function automatic int unsigned byte_count(input int unsigned w);
    return (w + 32'd7) / 32'd8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_xfer_datapath_chan_regs.sv
// ============================================================================
// dma_chan_regs -- one channel's base/current address and count registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_chan_regs #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_addr,
  input  logic              i_wr_cnt,
  input  logic [1:0]        i_byte_sel,
  input  logic [7:0]        i_wdata,
  input  logic              i_step,
  input  logic              i_dec,
  input  logic              i_reload,
  output logic [ADDR_W-1:0] o_cur_addr,
  output logic [CNT_W-1:0]  o_cur_cnt
);

  logic [ADDR_W-1:0] r_base_addr, r_cur_addr;
  logic [CNT_W-1:0]  r_base_cnt, r_cur_cnt;
  logic [ADDR_W-1:0] w_addr_mask, w_addr_data;
  logic [CNT_W-1:0]  w_cnt_mask, w_cnt_data;

  // A CPU byte write is a masked merge into the selected byte lane.
  always_comb begin
    w_addr_mask = '0;
    w_addr_data = '0;
    w_cnt_mask  = '0;
    w_cnt_data  = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      w_addr_mask[b] = ((b / 8) == int'(i_byte_sel));
      w_addr_data[b] = i_wdata[b % 8];
    end
    for (int b = 0; b < CNT_W; b++) begin
      w_cnt_mask[b] = ((b / 8) == int'(i_byte_sel));
      w_cnt_data[b] = i_wdata[b % 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base_addr <= '0;
      r_cur_addr  <= '0;
      r_base_cnt  <= '0;
      r_cur_cnt   <= '0;
    end else begin
      if (i_wr_addr) begin
        r_base_addr <= (r_base_addr & ~w_addr_mask) | (w_addr_data & w_addr_mask);
        r_cur_addr  <= (r_cur_addr & ~w_addr_mask) | (w_addr_data & w_addr_mask);
      end
      if (i_wr_cnt) begin
        r_base_cnt <= (r_base_cnt & ~w_cnt_mask) | (w_cnt_data & w_cnt_mask);
        r_cur_cnt  <= (r_cur_cnt & ~w_cnt_mask) | (w_cnt_data & w_cnt_mask);
      end
      if (i_reload) begin
        r_cur_addr <= r_base_addr;
        r_cur_cnt  <= r_base_cnt;
      end else if (i_step) begin
        r_cur_addr <= i_dec ? r_cur_addr - ADDR_W'(1) : r_cur_addr + ADDR_W'(1);
        r_cur_cnt  <= r_cur_cnt - CNT_W'(1);
      end
    end
  end

  assign o_cur_addr = r_cur_addr;
  assign o_cur_cnt  = r_cur_cnt;

endmodule

`default_nettype wire

// File: rtl/dma_xfer_datapath.sv
// ============================================================================
// dma_xfer_datapath -- multi-channel DMA address/count datapath and sequencer.
// Optional DMA_AUTOINIT_EN adds per-channel autoinit reload. Revision: 1.0
// ============================================================================
`default_nettype none

module dma_xfer_datapath
  import DmaPackage::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int ADDR_W = 16,
  parameter  int CNT_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [CH_W:0]     cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  input  logic              clr_ff,
  input  logic              xfer_start,
  input  logic [CH_W-1:0]   xfer_ch,
  input  logic              xfer_stop,
  input  logic              step,
  input  logic [NUM_CH-1:0] dec_mode,
`ifdef DMA_AUTOINIT_EN
  input  logic [NUM_CH-1:0] autoinit,
`endif
  output logic [ADDR_W-1:0] addr_out,
  output logic              adstb,
  output logic              busy,
  output logic              tc
);

  localparam logic [1:0] c_addr_last = 2'(byte_count(ADDR_W) - 1);
  localparam logic [1:0] c_cnt_last  = 2'(byte_count(CNT_W) - 1);

  dma_state_e        r_state;
  logic [CH_W-1:0]   r_ch;
  logic [1:0]        r_ptr;
  logic              r_tc;
  logic [7:0]        r_rdata;

  logic [ADDR_W-1:0] w_cur_addr [NUM_CH];
  logic [CNT_W-1:0]  w_cur_cnt  [NUM_CH];
  logic [NUM_CH-1:0] w_autoinit;
  logic [CH_W-1:0]   w_acc_ch;
  logic              w_acc_ch_ok, w_start_ch_ok;
  logic              w_idle, w_sel, w_acc_ok;
  logic [1:0]        w_ptr_last, w_ptr_next, w_byte_sel;
  logic [31:0]       w_rd_word;
  logic [7:0]        w_rd_byte;
  logic [ADDR_W-1:0] w_act_addr, w_next_addr;
  logic [CNT_W-1:0]  w_act_cnt;
  logic              w_do_step, w_terminal, w_reload, w_page_chg;

`ifdef DMA_AUTOINIT_EN
  assign w_autoinit = autoinit;
`else
  assign w_autoinit = '0;
`endif

  assign w_acc_ch = cpu_addr[CH_W:1];
  assign w_sel    = cpu_addr[0];

  // Channel numbers beyond NUM_CH only exist when NUM_CH is not a power of two.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_full_ch
      assign w_acc_ch_ok   = 1'b1;
      assign w_start_ch_ok = 1'b1;
    end else begin : g_part_ch
      assign w_acc_ch_ok   = (32'(w_acc_ch) < NUM_CH);
      assign w_start_ch_ok = (32'(xfer_ch) < NUM_CH);
    end
  endgenerate

  assign w_idle     = (r_state == ST_IDLE);
  assign w_acc_ok   = w_idle && (cpu_wr || cpu_rd) && w_acc_ch_ok;
  assign w_ptr_last = (w_sel == CNT_SEL) ? c_cnt_last : c_addr_last;
  assign w_ptr_next = (r_ptr >= w_ptr_last) ? 2'd0 : r_ptr + 2'd1;
  assign w_byte_sel = clr_ff ? 2'd0 : r_ptr;

  always_comb begin
    w_rd_word = '0;
    if (w_sel == CNT_SEL) w_rd_word[CNT_W-1:0] = w_cur_cnt[w_acc_ch];
    else                  w_rd_word[ADDR_W-1:0] = w_cur_addr[w_acc_ch];
  end
  assign w_rd_byte = w_rd_word[{w_byte_sel, 3'b000} +: 8];

  assign w_act_addr  = w_cur_addr[r_ch];
  assign w_act_cnt   = w_cur_cnt[r_ch];
  assign w_do_step   = (r_state == ST_ACTIVE) && step && !xfer_stop;
  assign w_terminal  = w_do_step && (w_act_cnt == '0);
  assign w_reload    = w_terminal && w_autoinit[r_ch];
  assign w_next_addr = dec_mode[r_ch] ? w_act_addr - ADDR_W'(1) : w_act_addr + ADDR_W'(1);
  assign w_page_chg  = (w_next_addr[ADDR_W-1:8] != w_act_addr[ADDR_W-1:8]);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_ptr   <= '0;
      r_tc    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_tc <= w_terminal;
      if (clr_ff)        r_ptr <= '0;
      else if (w_acc_ok) r_ptr <= w_ptr_next;
      if (w_acc_ok && cpu_rd) r_rdata <= w_rd_byte;
      case (r_state)
        ST_IDLE: begin
          if (xfer_start && w_start_ch_ok) begin
            r_state <= ST_STROBE;
            r_ch    <= xfer_ch;
          end
        end
        ST_STROBE: r_state <= xfer_stop ? ST_IDLE : ST_ACTIVE;
        ST_ACTIVE: begin
          if (xfer_stop)                    r_state <= ST_IDLE;
          else if (w_terminal)              r_state <= w_reload ? ST_STROBE : ST_IDLE;
          else if (w_do_step && w_page_chg) r_state <= ST_STROBE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic w_wr_hit, w_act_hit;
      assign w_wr_hit  = w_acc_ok && cpu_wr && (w_acc_ch == CH_W'(g));
      assign w_act_hit = (r_ch == CH_W'(g));

      dma_chan_regs #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
      ) u_regs (
        .clk        (CLK),
        .rst        (RESET),
        .i_wr_addr  (w_wr_hit && (w_sel == ADDR_SEL)),
        .i_wr_cnt   (w_wr_hit && (w_sel == CNT_SEL)),
        .i_byte_sel (w_byte_sel),
        .i_wdata    (cpu_wdata),
        .i_step     (w_do_step && w_act_hit),
        .i_dec      (dec_mode[g]),
        .i_reload   (w_reload && w_act_hit),
        .o_cur_addr (w_cur_addr[g]),
        .o_cur_cnt  (w_cur_cnt[g])
      );
    end
  endgenerate

  assign cpu_rdata = r_rdata;
  assign addr_out  = w_idle ? '0 : w_act_addr;
  assign adstb     = (r_state == ST_STROBE);
  assign busy      = !w_idle;
  assign tc        = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_dma_xfer_datapath.sv
// ============================================================================
// tb_dma_xfer_datapath -- directed self-checking bench for dma_xfer_datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dma_xfer_datapath;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cpu_wr, cpu_rd, clr_ff, xfer_start, xfer_stop, step;
  logic [2:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [1:0]  xfer_ch;
  logic [3:0]  dec_mode;
  logic [15:0] addr_out;
  logic        adstb, busy, tc;
`ifdef DMA_AUTOINIT_EN
  logic [3:0]  autoinit;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  dma_xfer_datapath #(.NUM_CH(4), .ADDR_W(16), .CNT_W(16)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .clr_ff     (clr_ff),
    .xfer_start (xfer_start),
    .xfer_ch    (xfer_ch),
    .xfer_stop  (xfer_stop),
    .step       (step),
    .dec_mode   (dec_mode),
`ifdef DMA_AUTOINIT_EN
    .autoinit   (autoinit),
`endif
    .addr_out   (addr_out),
    .adstb      (adstb),
    .busy       (busy),
    .tc         (tc)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a);
    cpu_addr = a; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic clear_ff();
    clr_ff = 1'b1;
    tick();
    clr_ff = 1'b0;
  endtask

  task automatic start(input logic [1:0] ch);
    xfer_ch = ch; xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; cpu_wr = 0; cpu_rd = 0; clr_ff = 0; xfer_start = 0; xfer_stop = 0;
    step = 0; cpu_addr = '0; cpu_wdata = '0; xfer_ch = '0; dec_mode = '0;
`ifdef DMA_AUTOINIT_EN
    autoinit = '0;
`endif
    tick(); tick();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0h want 0", busy); else n_pass++;
    n_total++; if (addr_out !== 16'h0) $display("FAIL reset_addr: got %h want 0000", addr_out); else n_pass++;
    n_total++; if ({adstb, tc} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {adstb, tc}); else n_pass++;
    n_total++; if (cpu_rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", cpu_rdata); else n_pass++;
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_cpu_rw();
    clear_ff();
    cpu_write(3'b010, 8'h34);
    cpu_write(3'b010, 8'h12);
    cpu_read(3'b010);
    n_total++; if (cpu_rdata !== 8'h34) $display("FAIL rw_byte0: got %h want 34", cpu_rdata); else n_pass++;
    cpu_read(3'b010);
    n_total++; if (cpu_rdata !== 8'h12) $display("FAIL rw_byte1: got %h want 12", cpu_rdata); else n_pass++;
  endtask

  task automatic test_burst();
    clear_ff();
    cpu_write(3'b000, 8'hFE); cpu_write(3'b000, 8'h00);
    cpu_write(3'b001, 8'h02); cpu_write(3'b001, 8'h00);
    dec_mode = 4'b0000;
    start(2'd0);
    n_total++; if ({busy, adstb} !== 2'b11) $display("FAIL burst_strobe1: got %b want 11", {busy, adstb}); else n_pass++;
    n_total++; if (addr_out !== 16'h00FE) $display("FAIL burst_addr0: got %h want 00fe", addr_out); else n_pass++;
    tick();
    n_total++; if (adstb !== 1'b0) $display("FAIL burst_strobe_len: got %0h want 0", adstb); else n_pass++;
    do_step();
    n_total++; if (addr_out !== 16'h00FF) $display("FAIL burst_addr1: got %h want 00ff", addr_out); else n_pass++;
    n_total++; if ({adstb, tc} !== 2'b00) $display("FAIL burst_step1_flags: got %b want 00", {adstb, tc}); else n_pass++;
    do_step();
    n_total++; if (addr_out !== 16'h0100) $display("FAIL burst_addr2: got %h want 0100", addr_out); else n_pass++;
    n_total++; if ({adstb, tc} !== 2'b10) $display("FAIL burst_page_strobe: got %b want 10", {adstb, tc}); else n_pass++;
    tick();
    do_step();
    n_total++; if ({tc, busy} !== 2'b10) $display("FAIL burst_tc: got %b want 10", {tc, busy}); else n_pass++;
    tick();
    n_total++; if (tc !== 1'b0) $display("FAIL burst_tc_len: got %0h want 0", tc); else n_pass++;
    cpu_read(3'b000);
    n_total++; if (cpu_rdata !== 8'h01) $display("FAIL burst_final_lo: got %h want 01", cpu_rdata); else n_pass++;
    cpu_read(3'b000);
    n_total++; if (cpu_rdata !== 8'h01) $display("FAIL burst_final_hi: got %h want 01", cpu_rdata); else n_pass++;
  endtask

  task automatic test_dec_wrap();
    clear_ff();
    cpu_write(3'b100, 8'h00); cpu_write(3'b100, 8'h00);
    cpu_write(3'b101, 8'h00); cpu_write(3'b101, 8'h00);
    dec_mode = 4'b0100;
    start(2'd2);
    tick();
    do_step();
    n_total++; if (tc !== 1'b1) $display("FAIL wrap_tc: got %0h want 1", tc); else n_pass++;
    dec_mode = 4'b0000;
    cpu_read(3'b100);
    n_total++; if (cpu_rdata !== 8'hFF) $display("FAIL wrap_addr_lo: got %h want ff", cpu_rdata); else n_pass++;
    cpu_read(3'b100);
    n_total++; if (cpu_rdata !== 8'hFF) $display("FAIL wrap_addr_hi: got %h want ff", cpu_rdata); else n_pass++;
    cpu_read(3'b101);
    n_total++; if (cpu_rdata !== 8'hFF) $display("FAIL wrap_cnt_lo: got %h want ff", cpu_rdata); else n_pass++;
  endtask

  task automatic test_stop();
    clear_ff();
    cpu_write(3'b011, 8'h05); cpu_write(3'b011, 8'h00);
    start(2'd1);
    n_total++; if (addr_out !== 16'h1234) $display("FAIL stop_addr: got %h want 1234", addr_out); else n_pass++;
    tick();
    cpu_write(3'b010, 8'h99);
    cpu_read(3'b010);
    n_total++; if (cpu_rdata !== 8'hFF) $display("FAIL busy_rd_ignored: got %h want ff", cpu_rdata); else n_pass++;
    step = 1'b1; xfer_stop = 1'b1;
    tick();
    step = 1'b0; xfer_stop = 1'b0;
    n_total++; if ({busy, tc} !== 2'b00) $display("FAIL stop_idle: got %b want 00", {busy, tc}); else n_pass++;
    tick();
    n_total++; if (tc !== 1'b0) $display("FAIL stop_no_tc: got %0h want 0", tc); else n_pass++;
    cpu_read(3'b010);
    n_total++; if (cpu_rdata !== 8'h34) $display("FAIL stop_keep_lo: got %h want 34", cpu_rdata); else n_pass++;
    cpu_read(3'b010);
    n_total++; if (cpu_rdata !== 8'h12) $display("FAIL stop_keep_hi: got %h want 12", cpu_rdata); else n_pass++;
    cpu_read(3'b011);
    n_total++; if (cpu_rdata !== 8'h05) $display("FAIL stop_keep_cnt: got %h want 05", cpu_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_ff();
    start(2'd1);
    tick();
    do_step();
    n_total++; if (addr_out !== 16'h1235) $display("FAIL mid_addr: got %h want 1235", addr_out); else n_pass++;
    step = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    n_total++; if ({busy, adstb, tc} !== 3'b000) $display("FAIL mid_async_flags: got %b want 000", {busy, adstb, tc}); else n_pass++;
    n_total++; if (addr_out !== 16'h0) $display("FAIL mid_async_addr: got %h want 0000", addr_out); else n_pass++;
    tick();
    RESET = 1'b0;
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (tc !== 1'b0) $display("FAIL mid_no_tc: cycle %0d got %0h want 0", i, tc); else n_pass++;
    end
    cpu_read(3'b010);
    n_total++; if (cpu_rdata !== 8'h00) $display("FAIL mid_regs_cleared: got %h want 00", cpu_rdata); else n_pass++;
  endtask

`ifdef DMA_AUTOINIT_EN
  task automatic test_autoinit();
    clear_ff();
    autoinit = 4'b1000;
    cpu_write(3'b110, 8'h10); cpu_write(3'b110, 8'h00);
    cpu_write(3'b111, 8'h01); cpu_write(3'b111, 8'h00);
    start(2'd3);
    tick();
    do_step();
    do_step();
    n_total++; if ({tc, busy, adstb} !== 3'b111) $display("FAIL auto_flags: got %b want 111", {tc, busy, adstb}); else n_pass++;
    n_total++; if (addr_out !== 16'h0010) $display("FAIL auto_addr: got %h want 0010", addr_out); else n_pass++;
    xfer_stop = 1'b1;
    tick();
    xfer_stop = 1'b0;
    autoinit = 4'b0000;
    cpu_read(3'b111);
    n_total++; if (cpu_rdata !== 8'h01) $display("FAIL auto_cnt: got %h want 01", cpu_rdata); else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_rw();
    test_burst();
    test_dec_wrap();
    test_stop();
    test_reset_mid();
`ifdef DMA_AUTOINIT_EN
    test_autoinit();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_xfer_datapath.md
DMA_XFER_DATAPATH -- requirements
Module: dma_xfer_datapath

Interface
REQ-001 Parameter NUM_CH, default 4: number of DMA channels, 1..8.
REQ-002 Parameter ADDR_W, default 16: address width, 9..32.
REQ-003 Parameter CNT_W, default 16: word-count width, 8..32.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high; ports CLK and RESET.
REQ-005 CLK  in  1  system clock, all state on rising edge.
REQ-006 RESET  in  1  asynchronous active-high reset.
REQ-007 cpu_wr  in  1  single-cycle CPU register write strobe, honoured only in IDLE.
REQ-008 cpu_rd  in  1  single-cycle CPU register read strobe, honoured only in IDLE.
REQ-009 cpu_addr  in  $clog2(NUM_CH)+1  bit0 = 0 address register, 1 count register; upper bits = channel.
REQ-010 cpu_wdata  in  8  write byte.
REQ-011 cpu_rdata  out  8  registered read byte, valid the cycle after cpu_rd.
REQ-012 clr_ff  in  1  clears the byte pointer.
REQ-013 xfer_start  in  1  starts service of channel xfer_ch.
REQ-014 xfer_ch  in  $clog2(NUM_CH)  channel to service.
REQ-015 xfer_stop  in  1  aborts service, returns to IDLE.
REQ-016 step  in  1  one transfer completed on the active channel.
REQ-017 dec_mode  in  NUM_CH  per channel: 1 = address decrements, 0 = increments.
REQ-018 addr_out  out  ADDR_W  current address of the active channel; 0 in IDLE.
REQ-019 adstb  out  1  one-cycle strobe: addr_out[ADDR_W-1:8] is new and must be latched.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 tc  out  1  one-cycle terminal-count pulse.

Function
REQ-022 Per channel: base and current address (ADDR_W), base and current count (CNT_W).
REQ-023 A CPU write SHALL load the addressed byte, chosen by the byte pointer, into both base and current copies.
REQ-024 A CPU read SHALL return the addressed byte of the current register.
REQ-025 The byte pointer SHALL advance on each accepted cpu_wr or cpu_rd, counting 0..ceil(W/8)-1 and wrapping to 0; W is the register width.
REQ-026 clr_ff SHALL zero the byte pointer and overrides a coincident access, which is still performed at byte 0.
REQ-027 FSM states: IDLE, STROBE, ACTIVE.
REQ-028 IDLE to STROBE on xfer_start; latch xfer_ch as the active channel.
REQ-029 In STROBE, adstb = 1 for exactly one cycle, then the FSM goes to ACTIVE.
REQ-030 In ACTIVE, a step SHALL apply on the next edge:
- current address +/-1 per dec_mode, wrapping modulo 2^ADDR_W;
- current count -1, wrapping modulo 2^CNT_W.
REQ-031 A step with current count == 0 is terminal: tc = 1 on the following cycle, then the FSM goes to IDLE; the channel is serviced for count+1 transfers.
REQ-032 A non-terminal step that changes address bits [ADDR_W-1:8] SHALL move the FSM to STROBE.
REQ-033 xfer_stop SHALL return the FSM to IDLE on the next edge and preserve current registers; it wins over a coincident step.
REQ-034 cpu_wr, cpu_rd and xfer_start outside IDLE SHALL be ignored.
REQ-035 xfer_start with xfer_ch >= NUM_CH SHALL be ignored.

Reset
REQ-036 RESET SHALL immediately force: FSM IDLE, all registers and byte pointer 0, addr_out 0, cpu_rdata 0, adstb 0, busy 0, tc 0.
REQ-037 RESET mid-transfer SHALL abandon the transfer with no tc pulse.

Configuration
REQ-038 Macro DMA_AUTOINIT_EN present adds input autoinit[NUM_CH-1:0].
- A terminal step on a channel with autoinit set SHALL reload current address and count from base on the same edge.
- tc SHALL still pulse, and the FSM SHALL go to STROBE instead of IDLE.
REQ-039 Without DMA_AUTOINIT_EN there is no autoinit port and terminal behaviour is REQ-031 only.

Structure
REQ-040 DmaPackage SHALL hold the FSM state enum typedef, the register-select constants (ADDR_SEL = 0, CNT_SEL = 1) and the byte-count function ceil(W/8).
REQ-041 One sub-module dma_chan_regs SHALL hold one channel's base/current pairs with load, step and reload ports; it is instantiated NUM_CH times.

Verification
REQ-042 clr_ff; write ch1 address bytes 0x34, 0x12; read twice -> cpu_rdata 0x34 then 0x12.
REQ-043 ch0 address 0x00FE, count 2, inc; start; 3 steps ->
- addr_out 0x00FE, 0x00FF, 0x0100;
- adstb in the first STROBE and again after 0x00FF->0x0100;
- tc after the third step; then IDLE.
REQ-044 dec_mode[2] = 1, address 0x0000, count 0; one step -> address wraps to 0xFFFF; tc pulses.
REQ-045 DMA_AUTOINIT_EN, autoinit[3] = 1, count 1; two steps -> tc, current registers equal base, FSM in STROBE.
REQ-046 RESET asserted mid-ACTIVE -> all outputs 0 immediately; tc never pulses.
REQ-047 step and xfer_stop in the same cycle -> IDLE, registers unchanged, no tc.
